// File: rtl/btle_crc24_if.sv
// BLE CRC24 stage bus: info-bit input side and CRC-appended output side.
// Signals: init value/load pulse, info_bit/valid/valid_last in, info_bit_after_crc24/valid/valid_last out.
// master = upstream bit source (also observes the output), slave = the CRC24 stage itself.
interface btle_crc24_if #(
  parameter int W = 24
);
  logic [W-1:0] crc_state_init_bit;
  logic         crc_state_init_bit_load;
  logic         info_bit;
  logic         info_bit_valid;
  logic         info_bit_valid_last;
  logic         info_bit_after_crc24;
  logic         info_bit_after_crc24_valid;
  logic         info_bit_after_crc24_valid_last;

  modport master (
    output crc_state_init_bit, crc_state_init_bit_load,
    output info_bit, info_bit_valid, info_bit_valid_last,
    input  info_bit_after_crc24, info_bit_after_crc24_valid, info_bit_after_crc24_valid_last
  );

  modport slave (
    input  crc_state_init_bit, crc_state_init_bit_load,
    input  info_bit, info_bit_valid, info_bit_valid_last,
    output info_bit_after_crc24, info_bit_after_crc24_valid, info_bit_after_crc24_valid_last
  );
endinterface

// File: rtl/btle_crc24.sv
// BLE link-layer CRC24 generator: forwards info bits (latency 1) while updating a 24-bit LFSR,
// then appends the 24 CRC bits LSB first and flags the last one; the LFSR then reloads from the stored init.
// Ports: clk, rst (async active-low), bus (btle_crc24_if.slave). No backpressure: info bits arriving during the tail are dropped.
// Option BTLE_CRC24_PACED_TAIL_EN: tail bits spaced CRC_BIT_GAP clocks apart instead of back-to-back.
module btle_crc24 #(
  parameter int CRC_STATE_BIT_WIDTH = 24,
  parameter int CRC_BIT_GAP         = 16
) (
  input  logic         clk,
  input  logic         rst,
  btle_crc24_if.slave  bus
);

  localparam int W = CRC_STATE_BIT_WIDTH;

`ifdef BTLE_CRC24_PACED_TAIL_EN
  localparam bit PACED = 1'b1;
`else
  localparam bit PACED = 1'b0;
`endif

  // A back-to-back tail is simply a paced tail with a gap of one clock.
  localparam int TAIL_GAP = PACED ? CRC_BIT_GAP : 1;
  localparam int GAP_W    = (TAIL_GAP > 1) ? $clog2(TAIL_GAP) : 1;
  localparam int CNT_W    = $clog2(W);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TAIL_GAP - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(W - 1);
  localparam logic [W-1:0]     TOP_BIT  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]     POLY     = W'(24'h5A6000);

  typedef enum logic {S_DATA, S_TAIL} state_t;

  state_t           st, st_nxt;
  logic [W-1:0]     lfsr, init_q;
  logic [W-1:0]     lfsr_base, lfsr_upd;
  logic [CNT_W-1:0] bit_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             load, accept, tail_emit, tail_done;
  logic             o_bit_nxt, o_vld_nxt, o_last_nxt;

  assign load = bus.crc_state_init_bit_load;

  // A load in the same cycle as a bit means the bit starts from the fresh init
  // value, and a load also pulls the block out of the tail so that bit is taken.
  assign accept    = bus.info_bit_valid && (load || st == S_DATA);
  assign tail_emit = (st == S_TAIL) && !load && (gap_cnt == GAP_LAST);
  assign tail_done = tail_emit && (bit_idx == BIT_LAST);

  always_comb begin
    lfsr_base = load ? bus.crc_state_init_bit : lfsr;
    lfsr_upd  = lfsr_base >> 1;
    if (lfsr_base[0] ^ bus.info_bit) begin
      lfsr_upd = (lfsr_upd | TOP_BIT) ^ POLY;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= S_DATA;
    end else begin
      st <= st_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    st_nxt = st;
    if (accept && bus.info_bit_valid_last) begin
      st_nxt = S_TAIL;
    end else if (load || tail_done) begin
      st_nxt = S_DATA;
    end
  end

  // Output logic (registered below to give the one-clock latency)
  always_comb begin
    o_bit_nxt  = 1'b0;
    o_vld_nxt  = 1'b0;
    o_last_nxt = 1'b0;
    if (accept) begin
      o_bit_nxt = bus.info_bit;
      o_vld_nxt = 1'b1;
    end else if (tail_emit) begin
      o_bit_nxt  = lfsr[bit_idx];
      o_vld_nxt  = 1'b1;
      o_last_nxt = tail_done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr                                <= '0;
      init_q                              <= '0;
      bit_idx                             <= '0;
      gap_cnt                             <= '0;
      bus.info_bit_after_crc24            <= 1'b0;
      bus.info_bit_after_crc24_valid      <= 1'b0;
      bus.info_bit_after_crc24_valid_last <= 1'b0;
    end else begin
      bus.info_bit_after_crc24            <= o_bit_nxt;
      bus.info_bit_after_crc24_valid      <= o_vld_nxt;
      bus.info_bit_after_crc24_valid_last <= o_last_nxt;

      if (load) begin
        init_q <= bus.crc_state_init_bit;
      end

      if (accept) begin
        lfsr <= lfsr_upd;
      end else if (load) begin
        lfsr <= bus.crc_state_init_bit;
      end else if (tail_done) begin
        lfsr <= init_q;
      end

      // Counters idle at zero outside the tail so the tail always starts clean.
      if (st != S_TAIL || load) begin
        bit_idx <= '0;
        gap_cnt <= '0;
      end else if (tail_emit) begin
        bit_idx <= bit_idx + 1'b1;
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btle_crc24.sv
// Bench for btle_crc24: directed frames, scoreboard of expected {bit,last} per output.
module tb_btle_crc24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef BTLE_CRC24_PACED_TAIL_EN
  localparam int GAP = 16;
`else
  localparam int GAP = 1;
`endif

  btle_crc24_if intf ();

  btle_crc24 #(.CRC_STATE_BIT_WIDTH(24), .CRC_BIT_GAP(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int cyc       = 0;
  logic [1:0] sb[$];      // {bit, last}
  int         out_cyc[$]; // cycle stamp of each observed output

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid output must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (intf.info_bit_after_crc24_valid_last === 1'b1)
        check("last_needs_valid", intf.info_bit_after_crc24_valid, 1);
      if (intf.info_bit_after_crc24_valid === 1'b1) begin
        out_cyc.push_back(cyc);
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0)
          check("out_bit_last", {intf.info_bit_after_crc24, intf.info_bit_after_crc24_valid_last},
                sb.pop_front());
      end
    end
  end

  // All drive tasks start and end at posedge+#1.
  task automatic send_bit(input bit b, input bit last, input bit ld, input logic [23:0] init,
                          input bit expect_out);
    intf.info_bit                = b;
    intf.info_bit_valid          = 1'b1;
    intf.info_bit_valid_last     = last;
    intf.crc_state_init_bit_load = ld;
    intf.crc_state_init_bit      = init;
    if (expect_out) sb.push_back({b, 1'b0});
    @(posedge clk); #1;
    intf.info_bit_valid          = 1'b0;
    intf.info_bit_valid_last     = 1'b0;
    intf.crc_state_init_bit_load = 1'b0;
  endtask

  task automatic load_init(input logic [23:0] init);
    intf.crc_state_init_bit      = init;
    intf.crc_state_init_bit_load = 1'b1;
    @(posedge clk); #1;
    intf.crc_state_init_bit_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_crc(input logic [23:0] c);
    for (int i = 0; i < 24; i++) sb.push_back({c[i], (i == 23)});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
    check(tag, sb.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] crc_step(input logic [23:0] s, input bit b);
    logic fb;
    fb = s[0] ^ b;
    s  = s >> 1;
    if (fb) s = (s | 24'h800000) ^ 24'h5A6000;
    return s;
  endfunction

  logic [23:0] model;
  logic [19:0] rnd;

  initial begin
    rst = 1'b0;
    intf.crc_state_init_bit      = '0;
    intf.crc_state_init_bit_load = 1'b0;
    intf.info_bit                = 1'b0;
    intf.info_bit_valid          = 1'b0;
    intf.info_bit_valid_last     = 1'b0;
    #12;
    check("rst_dat",  intf.info_bit_after_crc24, 0);
    check("rst_vld",  intf.info_bit_after_crc24_valid, 0);
    check("rst_last", intf.info_bit_after_crc24_valid_last, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // Test 1: init 0, eight zero bits at 1 bit / 16 clk; stray valid_last alone mid-frame.
    load_init(24'h000000);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0, (i == 7), 1'b0, 24'h0, 1'b1);
      if (i == 3) begin
        intf.info_bit_valid_last = 1'b1;
        idle(1);
        intf.info_bit_valid_last = 1'b0;
        idle(14);
      end else if (i != 7) begin
        idle(15);
      end
    end
    push_crc(24'h000000);
    drain("t1_drain");

    // Test 2: init 1, single 0 bit; bits driven during the tail are dropped.
    load_init(24'h000001);
    send_bit(1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
    push_crc(24'hDA6000);
    for (int i = 0; i < 3; i++) send_bit(1'b1, (i == 2), 1'b0, 24'h0, 1'b0);
    drain("t2_drain");

    // Test 3 (and tail cadence): init 0x555555, single 1 bit.
    load_init(24'h555555);
    out_cyc.delete();
    send_bit(1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
    push_crc(24'h2AAAAA);
    drain("t3_drain");
    check("t3_out_count", out_cyc.size(), 25);
    for (int i = 1; i < out_cyc.size(); i++)
      check("t3_gap", out_cyc[i] - out_cyc[i-1], GAP);

    // Test 4: load and first valid in the same cycle, then a frame with no reload.
    send_bit(1'b0, 1'b1, 1'b1, 24'h000001, 1'b1);
    push_crc(24'hDA6000);
    drain("t4a_drain");
    send_bit(1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
    push_crc(24'hDA6000);
    drain("t4b_drain");

    // Multi-bit advertising frame, back-to-back input bits.
    load_init(24'h555555);
    rnd   = 20'($urandom);
    model = 24'h555555;
    for (int i = 0; i < 20; i++) begin
      model = crc_step(model, rnd[i]);
      send_bit(rnd[i], (i == 19), 1'b0, 24'h0, 1'b1);
    end
    push_crc(model);
    drain("rnd_drain");

    // Test 5: reset while tail bit 10 is on the output.
    load_init(24'h555555);
    out_cyc.delete();
    send_bit(1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
    push_crc(24'h2AAAAA);
    for (int i = 0; i < 1000 && out_cyc.size() < 12; i++) begin @(negedge clk); #1; end
    check("t5_reach_bit10", (out_cyc.size() >= 12), 1);
    rst = 1'b0;
    #1;
    check("t5_rst_dat",  intf.info_bit_after_crc24, 0);
    check("t5_rst_vld",  intf.info_bit_after_crc24_valid, 0);
    check("t5_rst_last", intf.info_bit_after_crc24_valid_last, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);
    load_init(24'h555555);
    send_bit(1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
    push_crc(24'h2AAAAA);
    drain("t5_after_rst_drain");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
